// File: rtl/wr_ptr_full_if.sv
// Write-side FIFO pointer bus: request/sync-pointer in, address/pointer/flags out.
// Optional wr_ovf_cnt member exists only when WR_OVF_CNT_EN is defined.
interface wr_ptr_full_if #(
    parameter int ASIZE = 5
);
    logic             wr_en;
    logic [ASIZE:0]   wq2_rd_ptr;
    logic             wr_accept;
    logic [ASIZE-1:0] wr_addr;
    logic [ASIZE:0]   wr_ptr;
    logic             wr_full;
    logic             wr_almost_full;
    logic [ASIZE:0]   wr_level;
    logic             wr_overflow;
`ifdef WR_OVF_CNT_EN
    logic [7:0]       wr_ovf_cnt;

    modport master (
        output wr_en, wq2_rd_ptr,
        input  wr_accept, wr_addr, wr_ptr, wr_full, wr_almost_full,
               wr_level, wr_overflow, wr_ovf_cnt
    );
    modport slave (
        input  wr_en, wq2_rd_ptr,
        output wr_accept, wr_addr, wr_ptr, wr_full, wr_almost_full,
               wr_level, wr_overflow, wr_ovf_cnt
    );
`else
    modport master (
        output wr_en, wq2_rd_ptr,
        input  wr_accept, wr_addr, wr_ptr, wr_full, wr_almost_full,
               wr_level, wr_overflow
    );
    modport slave (
        input  wr_en, wq2_rd_ptr,
        output wr_accept, wr_addr, wr_ptr, wr_full, wr_almost_full,
               wr_level, wr_overflow
    );
`endif
endinterface

// File: rtl/wr_ptr_full.sv
// Async-FIFO write-domain pointer/full/level generator; WR_OVF_CNT_EN adds a saturating reject counter.
// Latency: wr_accept combinational; pointers, flags and level registered one edge after the event.
// Backpressure: wr_en blocked only by registered wr_full; rejected writes set sticky wr_overflow.
module wr_ptr_full #(
    parameter int ASIZE     = 5,
    parameter int AF_THRESH = 28
) (
    input  logic          wr_clk,
    input  logic          wr_rst_n,
    wr_ptr_full_if.slave  bus
);
    localparam int PW = ASIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          accept;
    logic          reject;
`ifdef WR_OVF_CNT_EN
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
`endif

    assign accept = bus.wr_en & ~full_q;
    assign reject = bus.wr_en & full_q;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(bus.wq2_rd_ptr >> i);
        end
    end

    // Full when the write pointer has lapped the read pointer by exactly one depth.
    assign full_cmp = {~bus.wq2_rd_ptr[ASIZE:ASIZE-1], bus.wq2_rd_ptr[ASIZE-2:0]};

    always_comb begin
        wbin_d  = wbin_q + PW'(accept);
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        full_d  = (wgray_d == full_cmp);
        level_d = wbin_d - rbin;
        afull_d = (level_d >= PW'(AF_THRESH));
`ifdef WR_OVF_CNT_EN
        ovf_cnt_d = ovf_cnt_q;
        if (reject && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
        ovf_d = (ovf_cnt_d != 8'd0);
`else
        ovf_d = ovf_q | reject;
`endif
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef WR_OVF_CNT_EN
            ovf_cnt_q <= 8'd0;
`endif
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
`ifdef WR_OVF_CNT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    assign bus.wr_accept      = accept;
    assign bus.wr_addr        = wbin_q[ASIZE-1:0];
    assign bus.wr_ptr         = wgray_q;
    assign bus.wr_full        = full_q;
    assign bus.wr_almost_full = afull_q;
    assign bus.wr_level       = level_q;
    assign bus.wr_overflow    = ovf_q;
`ifdef WR_OVF_CNT_EN
    assign bus.wr_ovf_cnt     = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_wr_ptr_full.sv
// Randomised and directed bench for wr_ptr_full against an occupancy-count model.
module tb_wr_ptr_full;
    localparam int ASIZE = 5;
    localparam int PW    = ASIZE + 1;
    localparam int DEPTH = 1 << ASIZE;
    localparam int AF    = 28;
    localparam int MOD   = 1 << PW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wr_ptr_full_if #(.ASIZE(ASIZE)) bus ();

    wr_ptr_full #(.ASIZE(ASIZE), .AF_THRESH(AF)) dut (
        .wr_clk   (clk),
        .wr_rst_n (rst_n),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: total writes and read count as plain integers modulo 2*DEPTH.
    int m_w, m_level, m_cnt;
    bit m_full, m_af, m_ovf;
    bit en;
    int rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic drive();
        bus.wr_en      = en;
        bus.wq2_rd_ptr = PW'(to_gray(rd));
    endtask

    task automatic check_all();
        chk("ptr",   32'(bus.wr_ptr),         32'(to_gray(m_w)));
        chk("addr",  32'(bus.wr_addr),        32'(m_w % DEPTH));
        chk("full",  32'(bus.wr_full),        32'(m_full));
        chk("afull", 32'(bus.wr_almost_full), 32'(m_af));
        chk("level", 32'(bus.wr_level),       32'(m_level));
        chk("ovf",   32'(bus.wr_overflow),    32'(m_ovf));
`ifdef WR_OVF_CNT_EN
        chk("ovfcnt", 32'(bus.wr_ovf_cnt),    32'(m_cnt));
`endif
    endtask

    task automatic tick();
        bit acc;
        drive();
        #1;
        chk("accept", 32'(bus.wr_accept), 32'(en && !m_full));
        @(posedge clk);
        if (!rst_n) begin
            m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            acc = en && !m_full;
            if (en && m_full) begin
                m_ovf = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (acc) m_w = (m_w + 1) % MOD;
            m_level = (m_w - rd + MOD) % MOD;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= AF);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; rd = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic writes(input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        en = 1'b0;
    endtask

    initial begin
        m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0; m_cnt = 0;
        en = 1'b1; rd = 0;
        drive();

        // Reset held with wr_en high: accept visible, state frozen at zero.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_ptr", 32'(bus.wr_ptr), 32'h0);
        chk("rst_lvl", 32'(bus.wr_level), 32'h0);
        rst_n = 1'b1;

        // Fill to full and overflow by two.
        en = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i == 1)  chk("fill_g1", 32'(bus.wr_ptr), 32'h01);
            if (i == 2)  chk("fill_g2", 32'(bus.wr_ptr), 32'h03);
            if (i == 3)  chk("fill_g3", 32'(bus.wr_ptr), 32'h02);
            if (i == 27) chk("af_27", 32'(bus.wr_almost_full), 32'h0);
            if (i == 28) chk("af_28", 32'(bus.wr_almost_full), 32'h1);
            if (i == 31) chk("full_31", 32'(bus.wr_full), 32'h0);
            if (i == 32) begin
                chk("full_32", 32'(bus.wr_full), 32'h1);
                chk("ptr_32", 32'(bus.wr_ptr), 32'h30);
                chk("lvl_32", 32'(bus.wr_level), 32'd32);
            end
        end
        chk("ovf_fill", 32'(bus.wr_overflow), 32'h1);
        chk("ptr_hold", 32'(bus.wr_ptr), 32'h30);
`ifdef WR_OVF_CNT_EN
        chk("cnt_fill", 32'(bus.wr_ovf_cnt), 32'd2);
`endif

        // Drain release then immediate refill.
        en = 1'b0; rd = 1;
        tick();
        chk("rel_full", 32'(bus.wr_full), 32'h0);
        chk("rel_lvl", 32'(bus.wr_level), 32'd31);
        en = 1'b1;
        tick();
        chk("refull", 32'(bus.wr_full), 32'h1);

        // Wrap-around: wbin=32, rbin=32, then 32 writes wrap the pointer to 0.
        do_reset();
        writes(32);
        for (int r = 1; r <= 32; r++) begin
            rd = r;
            tick();
        end
        chk("wrap_empty", 32'(bus.wr_level), 32'd0);
        writes(32);
        chk("wrap_ptr", 32'(bus.wr_ptr), 32'h00);
        chk("wrap_full", 32'(bus.wr_full), 32'h1);
        chk("wrap_lvl", 32'(bus.wr_level), 32'd32);
        writes(1);
        chk("wrap_rej", 32'(bus.wr_ptr), 32'h00);
        chk("wrap_ovf", 32'(bus.wr_overflow), 32'h1);

        // Simultaneous read and write at level 28.
        do_reset();
        writes(28);
        en = 1'b1; rd = 1;
        tick();
        en = 1'b0;
        chk("sim_lvl", 32'(bus.wr_level), 32'd28);
        chk("sim_af", 32'(bus.wr_almost_full), 32'h1);
        chk("sim_full", 32'(bus.wr_full), 32'h0);

        // Overflow, drain to level 20, then reset with wr_en high.
        writes(7);
        for (int r = 2; r <= 13; r++) begin
            rd = r;
            tick();
        end
        chk("pre_rst_lvl", 32'(bus.wr_level), 32'd20);
        chk("pre_rst_ovf", 32'(bus.wr_overflow), 32'h1);
        rst_n = 1'b0; en = 1'b1; rd = 0;
        tick();
        rst_n = 1'b1; en = 1'b0;
        chk("mid_rst_lvl", 32'(bus.wr_level), 32'd0);
        chk("mid_rst_ovf", 32'(bus.wr_overflow), 32'h0);

        // Saturation of the reject count.
        writes(32 + 260);
`ifdef WR_OVF_CNT_EN
        chk("cnt_sat", 32'(bus.wr_ovf_cnt), 32'd255);
`endif

        // Randomised traffic with a lagging read pointer.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            int p_en, p_rd;
            p_en = $urandom_range(10, 95);
            p_rd = $urandom_range(10, 95);
            for (int c = 0; c < 200; c++) begin
                en = ($urandom_range(0, 99) < p_en);
                if (($urandom_range(0, 99) < p_rd) && (((m_w - rd + MOD) % MOD) > 0))
                    rd = (rd + 1) % MOD;
                if ($urandom_range(0, 999) == 0) begin
                    rst_n = 1'b0; rd = 0;
                end
                tick();
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
